mux_sel_pipe: RTL and testbench
===============================

// Module: mux_sel_pipe
// PURPOSE
//   Parametrised N-way word selector with a valid/ready handshake and a 2-entry skid buffer.
//   Successor to the fixed 4:1 5-bit register-address selector in the datapath.
//   Sits between decode and the register-write stage; lets the pipeline stall on
//   out_ready without losing a selected word. Out-of-range index gives DEFAULT_VAL plus an
//   error flag, never high-Z.
// PARAMETERS
//   WIDTH        5              bits per input word and per output word
//   NUM_IN       4              number of selectable inputs, 2..32
//   SEL_W        $clog2(NUM_IN) index width; derived, do not override
//   DEFAULT_VAL  {WIDTH{1'b0}}  word driven when in_sel >= NUM_IN
// PORTS
//   clk        in   1             single clock, rising edge
//   rst_n      in   1             synchronous reset, active low
//   in_data    in   NUM_IN*WIDTH  flattened inputs; word i = in_data[i*WIDTH +: WIDTH]
//   in_sel     in   SEL_W         index of the word to select
//   in_valid   in   1             upstream beat valid
//   in_ready   out  1             block can accept a beat this cycle
//   out_data   out  WIDTH         selected word
//   out_err    out  1             beat came from an out-of-range index
//   out_valid  out  1             output beat valid
//   out_ready  in   1             downstream accepts the beat
// BEHAVIOUR
//   - Reset (rst_n low at posedge): state EMPTY, out_valid=0, out_data=0, out_err=0,
//     in_ready=1. Reset mid-transfer drops all buffered beats; nothing is replayed.
//   - Handshake: accept when in_valid&&in_ready; emit when out_valid&&out_ready.
//     out_data/out_err stay stable while out_valid&&!out_ready.
//   - Selection is done at accept time: word = (in_sel<NUM_IN) ? in_data[in_sel] : DEFAULT_VAL.
//     err = (in_sel>=NUM_IN). This check only matters when NUM_IN is not a power of 2.
//   - Latency: 1 cycle from accept to out_valid.
//   - Registers: main {data,err} drives the outputs; skid {data,err} holds the overflow beat.
//   - in_ready = (state!=FULL). It is a register output with no combinational path from
//     out_ready.
//   - FSM:
//       EMPTY: accept              -> ONE (load main)
//       ONE:   accept & !emit      -> FULL (load skid)
//              accept & emit       -> ONE (load main)
//              !accept & emit      -> EMPTY
//       FULL:  emit                -> ONE (main<=skid); no accept is possible in FULL
//   - Simultaneous accept+emit in ONE: throughput 1 beat/cycle, order preserved.
//   - out_valid = (state!=EMPTY).
//   - Ordering: strict FIFO order and no duplication, at any stall pattern.
// CONFIGURATION
//   MUX_SEL_BYPASS_EN defined:
//     - In EMPTY with in_valid && out_ready, the selected word goes straight to out_data
//       with out_valid=1 in the same cycle (0-cycle latency). State stays EMPTY.
//     - out_valid/out_data then depend combinationally on in_valid/in_sel/in_data.
//   MUX_SEL_BYPASS_EN undefined: always registered, 1-cycle latency as above.
// STRUCTURE
//   - Shared package mux_sel_pkg:
//       - state typedef {EMPTY=2'd0, ONE=2'd1, FULL=2'd2}
//       - function sel_word(data, sel) returning {err, word}, reused by the bypass path.
//   - One natural sub-module: mux_sel_comb (pure N:1 select plus range check,
//     parametrised WIDTH/NUM_IN). The top holds the FSM and the main/skid registers.
// TESTING (NUM_IN=5, WIDTH=5 unless noted)
//   1. Reset: hold rst_n=0 for 2 clks with in_valid=1
//      -> out_valid=0, out_data=0, out_err=0, in_ready=1.
//   2. Streaming: words {3,7,11,19,31}; sel 0..4 on 5 consecutive cycles, out_ready=1
//      -> out_data 3,7,11,19,31 on cycles 1..5, out_err=0, in_ready never drops.
//   3. Out of range: sel=6, DEFAULT_VAL=5'h1F
//      -> out_data=0x1F, out_err=1 for exactly that beat; next valid sel=1 gives 7, err=0.
//   4. Backpressure: out_ready=0 while 3 beats are offered
//      -> 2 beats accepted, in_ready=0 afterwards, out_data held. Release out_ready
//      -> beats drain in order, in_ready=1 the cycle after FULL->ONE.
//   5. Random valid/ready, 10k beats, NUM_IN=4 and NUM_IN=7
//      -> scoreboard shows no loss, duplication or reorder.
//   6. Reset while FULL, then release
//      -> out_valid=0 the next cycle; first post-reset beat is the only output.
//      With MUX_SEL_BYPASS_EN: in EMPTY, out_ready=1, sel=2 -> out_data=11 in the same cycle.

Source files
------------

// File: rtl/mux_sel_pkg.sv
// Shared types and the word-select helper for the mux_sel_pipe block.
// The helper works on maximum-size buses so every parametrisation can reuse it.
package mux_sel_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    localparam int MAX_W = 32;
    localparam int MAX_N = 32;

    typedef logic [MAX_N*MAX_W-1:0] bus_t;
    typedef logic [4:0]             sel_t;
    typedef logic [MAX_W-1:0]       word_t;

    // Returns {err, word}; word bits above 'width' are zero.
    function automatic logic [MAX_W:0] sel_word(input bus_t  data,
                                                input sel_t  sel,
                                                input int    width,
                                                input int    num_in,
                                                input word_t dflt);
        logic [MAX_W:0] res;
        logic [9:0]     idx;
        res = '0;
        if (int'(sel) < num_in) begin
            for (int b = 0; b < MAX_W; b++) begin
                idx = 10'(int'(sel) * width + b);
                if (b < width) res[b] = data[idx];
            end
        end else begin
            res = {1'b1, dflt};
        end
        return res;
    endfunction

endpackage

// File: rtl/mux_sel_comb.sv
// Pure N:1 word select with out-of-range detection; no state.
module mux_sel_comb
    import mux_sel_pkg::*;
#(
    parameter int              WIDTH       = 5,
    parameter int              NUM_IN      = 4,
    localparam int             SEL_W       = $clog2(NUM_IN),
    parameter logic [WIDTH-1:0] DEFAULT_VAL = '0
) (
    input  logic [NUM_IN*WIDTH-1:0] data_i,
    input  logic [SEL_W-1:0]        sel_i,
    output logic [WIDTH-1:0]        word_o,
    output logic                    err_o
);

    logic [MAX_W:0] sel_res;
    logic           unused_sel_res;

    assign sel_res        = sel_word(bus_t'(data_i), sel_t'(sel_i), WIDTH, NUM_IN,
                                     word_t'(DEFAULT_VAL));
    assign word_o         = sel_res[WIDTH-1:0];
    assign err_o          = sel_res[MAX_W];
    assign unused_sel_res = ^sel_res;

endmodule

// File: rtl/mux_sel_pipe.sv
// N-way word selector with valid/ready handshake and a main+skid buffer.
// Optional MUX_SEL_BYPASS_EN: zero-latency pass-through while the buffer is empty.
module mux_sel_pipe
    import mux_sel_pkg::*;
#(
    parameter int               WIDTH       = 5,
    parameter int               NUM_IN      = 4,
    localparam int              SEL_W       = $clog2(NUM_IN),
    parameter logic [WIDTH-1:0] DEFAULT_VAL = '0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]        in_sel,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_err,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [1:0]              dbg_state_o
);

    logic [WIDTH-1:0] sel_data;
    logic             sel_err;
    state_t           state_q;
    logic [WIDTH-1:0] main_data_q, skid_data_q;
    logic             main_err_q, skid_err_q;
    logic             in_ready_q, out_valid_q;
    logic             accept, bypass;

    mux_sel_comb #(
        .WIDTH      (WIDTH),
        .NUM_IN     (NUM_IN),
        .DEFAULT_VAL(DEFAULT_VAL)
    ) u_comb (
        .data_i(in_data),
        .sel_i (in_sel),
        .word_o(sel_data),
        .err_o (sel_err)
    );

`ifdef MUX_SEL_BYPASS_EN
    assign bypass = (state_q == EMPTY) && in_valid && out_ready;
`else
    assign bypass = 1'b0;
`endif

    // Handshake: a beat moves on a side when its valid and ready are both high
    // at the rising edge; in_ready never depends on out_ready in the same cycle.
    assign accept = in_valid && in_ready_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= EMPTY;
            main_data_q <= '0;
            main_err_q  <= 1'b0;
            skid_data_q <= '0;
            skid_err_q  <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept && !bypass) begin
                        main_data_q <= sel_data;
                        main_err_q  <= sel_err;
                        out_valid_q <= 1'b1;
                        state_q     <= ONE;
                    end
                end
                ONE: begin
                    if (accept && !out_ready) begin
                        skid_data_q <= sel_data;
                        skid_err_q  <= sel_err;
                        in_ready_q  <= 1'b0;
                        state_q     <= FULL;
                    end else if (accept) begin
                        main_data_q <= sel_data;
                        main_err_q  <= sel_err;
                    end else if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= EMPTY;
                    end
                end
                FULL: begin
                    if (out_ready) begin
                        main_data_q <= skid_data_q;
                        main_err_q  <= skid_err_q;
                        in_ready_q  <= 1'b1;
                        state_q     <= ONE;
                    end
                end
                default: begin
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    state_q     <= EMPTY;
                end
            endcase
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q | bypass;
    assign out_data    = bypass ? sel_data : main_data_q;
    assign out_err     = bypass ? sel_err  : main_err_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mux_sel_pipe.sv
// Bench for mux_sel_pipe (NUM_IN=5, WIDTH=5, DEFAULT_VAL=0x1F): directed cases plus
// random valid/ready traffic against a queue-based reference of {err, word} beats.
module tb_mux_sel_pipe;

    localparam int         WIDTH  = 5;
    localparam int         NUM_IN = 5;
    localparam logic [4:0] DEF    = 5'h1F;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [24:0] in_data;
    logic [2:0]  in_sel;
    logic        in_valid, in_ready;
    logic [4:0]  out_data;
    logic        out_err, out_valid, out_ready;
    logic [1:0]  dbg_state;

    int n_checks = 0;
    int n_fail   = 0;
    int n_acc    = 0;
    int n_emit   = 0;
    logic [5:0] exp_q[$];

    mux_sel_pipe #(
        .WIDTH      (WIDTH),
        .NUM_IN     (NUM_IN),
        .DEFAULT_VAL(DEF)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_data    (in_data),
        .in_sel     (in_sel),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_data   (out_data),
        .out_err    (out_err),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .dbg_state_o(dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // {err, word} for a selection, straight from the selection rule.
    function automatic logic [5:0] ref_sel(input logic [24:0] d, input int sel);
        logic [24:0] sh;
        if (sel >= NUM_IN) return {1'b1, DEF};
        sh = d >> (sel * WIDTH);
        return {1'b0, sh[4:0]};
    endfunction

    // Called at a negedge with inputs set; checks, crosses one posedge, returns at negedge.
    task automatic cycle();
        logic       acc, emit, byp;
        logic [5:0] head, cur;
        #1;
        cur = ref_sel(in_data, int'(in_sel));
        byp = 1'b0;
`ifdef MUX_SEL_BYPASS_EN
        byp = rst_n && (exp_q.size() == 0) && in_valid && out_ready;
`endif
        acc  = in_valid && in_ready;
        emit = out_valid && out_ready;
        if (rst_n) begin
            check("out_valid", 32'(out_valid), 32'((exp_q.size() != 0) || byp));
            check("in_ready", 32'(in_ready), 32'(exp_q.size() < 2));
            if (emit) begin
                head = byp ? cur : ((exp_q.size() != 0) ? exp_q[0] : 6'h3F);
                check("out_data", 32'(out_data), 32'(head[4:0]));
                check("out_err", 32'(out_err), 32'(head[5]));
            end
        end
        @(posedge clk);
        if (!rst_n) begin
            exp_q.delete();
        end else begin
            if (emit) begin
                n_emit++;
                if (!byp && exp_q.size() != 0) void'(exp_q.pop_front());
            end
            if (acc) begin
                n_acc++;
                if (!byp) exp_q.push_back(cur);
            end
        end
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input int sel, input logic r);
        in_valid  = v;
        in_sel    = 3'(sel);
        out_ready = r;
        cycle();
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) drive(1'b0, 0, 1'b1);
        check("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic summary();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        n_fail++;
        summary();
        $fatal(1, "watchdog");
    end

    initial begin
        int a0, e0;
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        in_sel    = 3'd0;
        out_ready = 1'b0;
        in_data   = {5'd31, 5'd19, 5'd11, 5'd7, 5'd3};

        // Reset held for two clocks with in_valid high.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_err", 32'(out_err), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        rst_n    = 1'b1;
        in_valid = 1'b0;

        // Streaming: sel 0..4 back to back.
        e0 = n_emit;
        for (int k = 0; k < 5; k++) drive(1'b1, k, 1'b1);
        drain();
        check("stream_emits", 32'(n_emit - e0), 32'd5);

        // Out-of-range index, then a valid one.
        drive(1'b1, 6, 1'b1);
        check("oor_data", 32'(out_data), 32'h1F);
        check("oor_err", 32'(out_err), 32'd1);
        drive(1'b1, 1, 1'b1);
        check("oor_next_data", 32'(out_data), 32'd7);
        check("oor_next_err", 32'(out_err), 32'd0);
        drain();

        // Backpressure: three offers with out_ready low.
        a0 = n_acc;
        drive(1'b1, 1, 1'b0);
        drive(1'b1, 2, 1'b0);
        drive(1'b1, 3, 1'b0);
        check("bp_accepts", 32'(n_acc - a0), 32'd2);
        check("bp_hold_data", 32'(out_data), 32'd7);
        check("bp_in_ready", 32'(in_ready), 32'd0);
        drive(1'b0, 0, 1'b1);
        check("bp_ready_back", 32'(in_ready), 32'd1);
        check("bp_next_data", 32'(out_data), 32'd11);
        drain();

        // Reset while FULL drops both buffered beats.
        drive(1'b1, 0, 1'b0);
        drive(1'b1, 1, 1'b0);
        check("full_in_ready", 32'(in_ready), 32'd0);
        rst_n = 1'b0;
        drive(1'b1, 2, 1'b0);
        rst_n = 1'b1;
        check("post_rst_valid", 32'(out_valid), 32'd0);
        e0 = n_emit;
        drive(1'b0, 0, 1'b1);
        drive(1'b1, 4, 1'b1);
        check("post_rst_data", 32'(out_data), 32'd31);
        drain();
        check("post_rst_emits", 32'(n_emit - e0), 32'd1);

`ifdef MUX_SEL_BYPASS_EN
        in_data   = {5'd31, 5'd19, 5'd11, 5'd7, 5'd3};
        in_valid  = 1'b1;
        in_sel    = 3'd2;
        out_ready = 1'b1;
        #1;
        check("bypass_data", 32'(out_data), 32'd11);
        check("bypass_valid", 32'(out_valid), 32'd1);
        cycle();
        drain();
`endif

        // Random traffic.
        a0 = n_acc;
        e0 = n_emit;
        for (int i = 0; i < 3000; i++) begin
            in_data = 25'($urandom);
            drive(($urandom_range(0, 9) < 7), int'($urandom_range(0, 7)),
                  ($urandom_range(0, 9) < 6));
        end
        drain();
        check("rand_no_loss", 32'(n_emit - e0), 32'(n_acc - a0));

        summary();
        $finish;
    end

endmodule
